psum_acc_ctrl: RTL and testbench
================================

PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 The block SHALL have parameter PSUM_W, default 8, giving the partial-sum width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the scratchpad address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a pulse that launches a job.
REQ-006 The block SHALL have port cfg_len, input, ADDR_W bits: number of psums per pass, sampled at start.
REQ-007 The block SHALL have port cfg_passes, input, 4 bits: number of accumulation passes, sampled at start.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.
REQ-010 The block SHALL have port prod_valid, input, 1 bit: MAC product valid.
REQ-011 The block SHALL have port prod_data, input, PSUM_W bits: MAC product value.
REQ-012 The block SHALL have port prod_ready, output, 1 bit: the controller accepts the product.
REQ-013 The block SHALL have port spad_rd, output, 1 bit: psum scratchpad read strobe.
REQ-014 The block SHALL have port spad_wr, output, 1 bit: psum scratchpad write strobe.
REQ-015 The block SHALL have port spad_addr, output, ADDR_W bits: scratchpad address.
REQ-016 The block SHALL have port spad_wdata, output, PSUM_W bits: scratchpad write data.
REQ-017 The block SHALL have port spad_rdata, input, PSUM_W bits: scratchpad read data, valid one cycle after spad_rd.
REQ-018 The block SHALL have port out_valid, output, 1 bit: final psum valid.
REQ-019 The block SHALL have port out_data, output, PSUM_W bits: final psum value.
REQ-020 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the final psum.
REQ-021 The block SHALL have port ovf, output, 1 bit: sticky flag indicating an add carry-out occurred in the current job.

Function
REQ-022 The state machine SHALL have exactly the states IDLE, INIT, ACC_REQ, ACC_WR, DRAIN_REQ, DRAIN_OUT and DONE, with registers idx (ADDR_W bits) and pass (4 bits).
REQ-023 In IDLE, start=1 with cfg_len!=0 and cfg_passes!=0 SHALL latch both configuration values, clear idx, pass and ovf, and go to INIT; otherwise start SHALL be ignored.
REQ-024 start asserted in any state other than IDLE SHALL be ignored.
REQ-025 INIT (pass 0) SHALL drive prod_ready=1; on each prod handshake it SHALL drive, combinationally in the same cycle, spad_wr=1, spad_addr=idx and spad_wdata=prod_data, then increment idx, giving a throughput of one psum per cycle.
REQ-026 When the INIT handshake occurs at idx=len-1, the block SHALL set idx to 0 and pass to 1, and go to ACC_REQ if passes>1, else to DRAIN_REQ.
REQ-027 ACC_REQ SHALL drive prod_ready=1; on a handshake it SHALL drive spad_rd=1 and spad_addr=idx in the same cycle, register prod_data, and go to ACC_WR.
REQ-028 ACC_WR SHALL drive prod_ready=0, spad_wr=1, spad_addr=idx and spad_wdata=(spad_rdata+prod_reg) mod 2^PSUM_W; a carry-out SHALL set ovf.
REQ-029 ACC_WR SHALL then increment idx and return to ACC_REQ, giving a throughput of one psum per two cycles.
REQ-030 At idx=len-1 in ACC_WR, idx SHALL wrap to 0 and pass SHALL increment; if pass+1==passes the next state SHALL be DRAIN_REQ, else ACC_REQ.
REQ-031 DRAIN_REQ SHALL drive spad_rd=1 and spad_addr=idx, then go to DRAIN_OUT.
REQ-032 DRAIN_OUT SHALL register spad_rdata into out_data on entry, assert out_valid, and hold out_data and out_valid stable until out_ready=1.
REQ-033 On the out_valid and out_ready handshake, idx SHALL increment and the state SHALL go to DRAIN_REQ, or to DONE if idx==len-1.
REQ-034 DONE SHALL assert done for exactly one cycle, keep ovf, then go to IDLE.
REQ-035 spad_rd and spad_wr SHALL never be high in the same cycle.
REQ-036 Strobes, prod_ready and out_valid SHALL be 0 in IDLE and DONE; spad_addr and spad_wdata are don't-care when their strobe is 0.
REQ-037 An input held with prod_valid=0 SHALL stall the block in INIT or ACC_REQ indefinitely without changing state.
REQ-038 out_ready=0 SHALL stall DRAIN_OUT indefinitely without issuing any spad access.

Reset
REQ-039 rst=1 SHALL override all other inputs in that cycle.
REQ-040 rst=1 SHALL force IDLE and clear idx, pass, len, passes, prod_reg, out_data, out_valid, done and ovf to 0.
REQ-041 In a cycle with rst=1, spad_rd, spad_wr and prod_ready SHALL be 0, so a reset mid-job issues no scratchpad access.
REQ-042 The first start SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-043 Scenario: len=4, passes=1, products 1,2,3,4 back-to-back -> 4 writes in 4 consecutive cycles to addr 0..3, then out_data 1,2,3,4, then a single done pulse.
REQ-044 Scenario: len=3, passes=3, all products=5 -> each ACC_REQ read is followed by a write of the read value + 5; final outputs are 15,15,15 and ovf=0.
REQ-045 Scenario: len=1, passes=2, products 200 then 100 -> write 200, then write 44 (300 mod 256), ovf=1, out_data=44.
REQ-046 Scenario: prod_valid gaps and out_ready held low for 5 cycles -> no extra strobes, out_data stable, and final values unchanged versus the no-stall run.
REQ-047 Scenario: rst pulsed during ACC_WR of pass 1 -> next cycle busy=0 and all outputs 0; a new start with len=2, passes=1 then completes normally.
REQ-048 Scenario: start with cfg_len=0, and start while busy -> both ignored; busy stays 0 in the first case, and the running job is undisturbed in the second.

Source files
------------

// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulation controller: first pass stores products, later passes read-add-write
// into the psum scratchpad, and a final drain streams every psum to the downstream consumer.
module psum_acc_ctrl #(
  parameter int PSUM_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [3:0]        cfg_passes,
  output logic              busy,
  output logic              done,
  input  logic              prod_valid,
  input  logic [PSUM_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              spad_rd,
  output logic              spad_wr,
  output logic [ADDR_W-1:0] spad_addr,
  output logic [PSUM_W-1:0] spad_wdata,
  input  logic [PSUM_W-1:0] spad_rdata,
  output logic              out_valid,
  output logic [PSUM_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ovf
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INIT      = 3'd1;
  localparam logic [2:0] ACC_REQ   = 3'd2;
  localparam logic [2:0] ACC_WR    = 3'd3;
  localparam logic [2:0] DRAIN_REQ = 3'd4;
  localparam logic [2:0] DRAIN_OUT = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] len;
  logic [3:0]        pass;
  logic [3:0]        passes;
  logic [PSUM_W-1:0] prod_reg;
  logic [PSUM_W:0]   sum;
  logic              last_idx;

  // The extra top bit of sum is the carry that feeds the sticky overflow flag.
  assign sum      = {1'b0, spad_rdata} + {1'b0, prod_reg};
  assign last_idx = (idx == (len - IDX_ONE));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Scratchpad strobes and product handshake; all forced low while rst is high.
  always_comb begin
    prod_ready = 1'b0;
    spad_rd    = 1'b0;
    spad_wr    = 1'b0;
    spad_addr  = IDX_ZERO;
    spad_wdata = {PSUM_W{1'b0}};
    if (rst) begin
      prod_ready = 1'b0;
    end else begin
      case (state)
        INIT: begin
          prod_ready = 1'b1;
          spad_wr    = prod_valid;
          spad_addr  = idx;
          spad_wdata = prod_data;
        end
        ACC_REQ: begin
          prod_ready = 1'b1;
          spad_rd    = prod_valid;
          spad_addr  = idx;
        end
        ACC_WR: begin
          spad_wr    = 1'b1;
          spad_addr  = idx;
          spad_wdata = sum[PSUM_W-1:0];
        end
        DRAIN_REQ: begin
          spad_rd    = 1'b1;
          spad_addr  = idx;
        end
        DRAIN_OUT: begin
          spad_addr  = idx;
        end
        default: begin
          prod_ready = 1'b0;
        end
      endcase
    end
  end

  // Job sequencing, index/pass counters, captured product and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= IDX_ZERO;
      len       <= IDX_ZERO;
      pass      <= 4'd0;
      passes    <= 4'd0;
      prod_reg  <= {PSUM_W{1'b0}};
      out_data  <= {PSUM_W{1'b0}};
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (cfg_len != IDX_ZERO) && (cfg_passes != 4'd0)) begin
            len    <= cfg_len;
            passes <= cfg_passes;
            idx    <= IDX_ZERO;
            pass   <= 4'd0;
            ovf    <= 1'b0;
            state  <= INIT;
          end
        end
        INIT: begin
          if (prod_valid) begin
            if (last_idx) begin
              idx   <= IDX_ZERO;
              pass  <= 4'd1;
              state <= (passes > 4'd1) ? ACC_REQ : DRAIN_REQ;
            end else begin
              idx   <= idx + IDX_ONE;
            end
          end
        end
        ACC_REQ: begin
          if (prod_valid) begin
            prod_reg <= prod_data;
            state    <= ACC_WR;
          end
        end
        ACC_WR: begin
          if (sum[PSUM_W]) begin
            ovf <= 1'b1;
          end
          if (last_idx) begin
            idx   <= IDX_ZERO;
            pass  <= pass + 4'd1;
            state <= ((pass + 4'd1) == passes) ? DRAIN_REQ : ACC_REQ;
          end else begin
            idx   <= idx + IDX_ONE;
            state <= ACC_REQ;
          end
        end
        DRAIN_REQ: begin
          state <= DRAIN_OUT;
        end
        // First DRAIN_OUT cycle captures the read data; out_valid then holds until accepted.
        DRAIN_OUT: begin
          if (!out_valid) begin
            out_data  <= spad_rdata;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (last_idx) begin
              idx   <= IDX_ZERO;
              state <= DONE;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= DRAIN_REQ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl: directed vector table, hand-written corner sequences
// and randomized jobs checked against a transaction-level accumulation model.
module tb_psum_acc_ctrl;
  localparam int W  = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_len;
  logic [3:0]    cfg_passes;
  logic          busy, done;
  logic          prod_valid;
  logic [W-1:0]  prod_data;
  logic          prod_ready;
  logic          spad_rd, spad_wr;
  logic [AW-1:0] spad_addr;
  logic [W-1:0]  spad_wdata;
  logic [W-1:0]  spad_rdata;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          ovf;

  always #5 clk = ~clk;

  psum_acc_ctrl #(.PSUM_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
    .busy(busy), .done(done), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_ready(prod_ready), .spad_rd(spad_rd), .spad_wr(spad_wr), .spad_addr(spad_addr),
    .spad_wdata(spad_wdata), .spad_rdata(spad_rdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .ovf(ovf)
  );

  // Scratchpad: synchronous write, read data appears the cycle after spad_rd.
  logic [W-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (spad_wr) mem[spad_addr] <= spad_wdata;
    if (spad_rd) spad_rdata <= mem[spad_addr];
  end

  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  int errors = 0;
  int checks = 0;
  int prod_q[$];
  int got_q[$];
  int exp_q[$];
  int exp_ovf;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int rd_cnt;
  int done_cnt;

  typedef struct {
    int len; int passes; int base0; int base1; int step; bit stall;
    int e0; int e1; int e2; int e3; int eovf;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: psum[i] is the running sum of pass products mod 256; ovf if any add carries.
  function automatic void build_model(input int len, input int passes);
    int acc[$];
    int t;
    exp_q.delete();
    exp_ovf = 0;
    for (int i = 0; i < len; i++) acc.push_back(prod_q[i]);
    for (int p = 1; p < passes; p++) begin
      for (int i = 0; i < len; i++) begin
        t = acc[i] + prod_q[p*len + i];
        if (t > 255) exp_ovf = 1;
        acc[i] = t % 256;
      end
    end
    exp_q = acc;
  endfunction

  task automatic run_job(input int len, input int passes, input bit stall, input bit poke);
    int cyc, hold, held, pi;
    bit fin;
    got_q.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rd_cnt = 0; done_cnt = 0; held = 0;
    @(negedge clk);
    start = 1'b1; cfg_len = AW'(len); cfg_passes = 4'(passes);
    @(negedge clk);
    start = 1'b0; cfg_len = '0; cfg_passes = '0;
    chk("busy_after_start", 32'(busy), 1);
    pi = 0; cyc = 0; fin = 1'b0; hold = stall ? 5 : 0;
    while (!fin && cyc < 3000) begin
      prod_valid = (pi < prod_q.size()) && (!stall || $urandom_range(0, 2) != 0);
      prod_data  = prod_valid ? W'(prod_q[pi]) : W'($urandom_range(0, 255));
      out_ready  = !(stall && hold > 0);
      if (poke && cyc == 3) begin
        start = 1'b1; cfg_len = AW'(1); cfg_passes = 4'd1;
      end else begin
        start = 1'b0; cfg_len = '0; cfg_passes = '0;
      end
      #1;
      if (spad_rd && spad_wr) chk("rd_wr_exclusive", 1, 0);
      if (spad_wr) begin
        wr_addr.push_back(int'(spad_addr)); wr_data.push_back(int'(spad_wdata)); wr_cyc.push_back(cyc_g);
      end
      if (spad_rd) rd_cnt++;
      if (prod_valid && prod_ready) pi++;
      if (out_valid) begin
        if (!out_ready) begin
          if (hold == 5) held = int'(out_data);
          else chk("out_hold_stable", int'(out_data), held);
          chk("no_strobe_in_stall", 32'(spad_rd | spad_wr), 0);
          hold--;
        end else begin
          got_q.push_back(int'(out_data));
          hold = stall ? 5 : 0;
        end
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    prod_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    if (!fin) chk("job_timeout", 0, 1);
    #1;
    chk("busy_after_done", 32'(busy), 0);
    chk("done_low_after", 32'(done), 0);
  endtask

  task automatic check_job(input int len, input int passes, input bit stall);
    chk("out_count", got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++) chk("out_data_vs_model", got_q[i], exp_q[i]);
    chk("ovf_vs_model", 32'(ovf), exp_ovf);
    chk("wr_count", wr_addr.size(), len*passes);
    chk("rd_count", rd_cnt, len*passes);
    chk("done_pulses", done_cnt, 1);
    if (!stall && wr_addr.size() >= len) begin
      for (int i = 0; i < len; i++) begin
        chk("init_wr_addr", wr_addr[i], i);
        chk("init_wr_data", wr_data[i], prod_q[i]);
        chk("init_wr_cycle", wr_cyc[i] - wr_cyc[0], i);
      end
    end
    if (wr_data.size() > 0) chk("last_wr_data", wr_data[wr_data.size()-1], exp_q[len-1]);
  endtask

  initial begin
    int ev[4];
    int len, passes, pi, n;
    bit seen, stl, pk;

    tv[0] = '{4, 1,   1,   0, 1, 1'b0,  1,  2,  3, 4, 0};
    tv[1] = '{3, 3,   5,   5, 0, 1'b0, 15, 15, 15, 0, 0};
    tv[2] = '{1, 2, 200, 100, 0, 1'b0, 44,  0,  0, 0, 1};
    tv[3] = '{4, 1,   1,   0, 1, 1'b1,  1,  2,  3, 4, 0};
    tv[4] = '{3, 3,   5,   5, 0, 1'b1, 15, 15, 15, 0, 0};

    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_passes = '0;
    prod_valid = 1'b0; prod_data = '0; out_ready = 1'b0; spad_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_prod_ready", 32'(prod_ready), 0);
    chk("rst_strobes", 32'(spad_rd | spad_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_done", 32'(done), 0);

    // First start in the very cycle reset drops
    @(negedge clk);
    rst = 1'b0; start = 1'b1; cfg_len = AW'(2); cfg_passes = 4'd1;
    @(negedge clk);
    start = 1'b0; cfg_len = '0; cfg_passes = '0;
    chk("first_start_accepted", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_busy", 32'(busy), 0);

    for (int v = 0; v < 5; v++) begin
      prod_q.delete();
      for (int p = 0; p < tv[v].passes; p++)
        for (int i = 0; i < tv[v].len; i++)
          prod_q.push_back((p == 0 ? tv[v].base0 : tv[v].base1) + tv[v].step * i);
      build_model(tv[v].len, tv[v].passes);
      run_job(tv[v].len, tv[v].passes, tv[v].stall, 1'b0);
      check_job(tv[v].len, tv[v].passes, tv[v].stall);
      ev[0] = tv[v].e0; ev[1] = tv[v].e1; ev[2] = tv[v].e2; ev[3] = tv[v].e3;
      for (int i = 0; i < tv[v].len && i < got_q.size(); i++) chk("table_out_data", got_q[i], ev[i]);
      chk("table_ovf", 32'(ovf), tv[v].eovf);
    end

    // Start ignored with zero length or zero passes
    @(negedge clk);
    start = 1'b1; cfg_len = '0; cfg_passes = 4'd3;
    @(negedge clk);
    start = 1'b1; cfg_len = AW'(3); cfg_passes = 4'd0;
    #1 chk("zero_len_ignored", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0; cfg_len = '0; cfg_passes = '0;
    #1 chk("zero_passes_ignored", 32'(busy), 0);

    // Reset during ACC_WR of pass 1
    prod_q = '{200, 20, 100, 40};
    @(negedge clk);
    start = 1'b1; cfg_len = AW'(2); cfg_passes = 4'd2;
    @(negedge clk);
    start = 1'b0; cfg_len = '0; cfg_passes = '0;
    pi = 0; n = 0; seen = 1'b0; out_ready = 1'b1;
    while (!seen && n < 20) begin
      prod_valid = 1'b1; prod_data = W'(prod_q[pi]);
      #1;
      if (spad_rd && prod_ready) seen = 1'b1;
      if (prod_ready) pi++;
      n++;
      @(negedge clk);
    end
    prod_valid = 1'b0;
    if (!seen) chk("reach_acc_req", 0, 1);
    #1 chk("acc_wr_write", 32'(spad_wr), 1);
    rst = 1'b1;
    #1;
    chk("midrst_no_wr", 32'(spad_wr), 0);
    chk("midrst_no_rd", 32'(spad_rd), 0);
    chk("midrst_prod_ready", 32'(prod_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_busy", 32'(busy), 0);
    chk("postrst_out_valid", 32'(out_valid), 0);
    chk("postrst_out_data", int'(out_data), 0);
    chk("postrst_ovf", 32'(ovf), 0);
    chk("postrst_done", 32'(done), 0);
    chk("postrst_strobes", 32'(spad_rd | spad_wr | prod_ready), 0);
    chk("postrst_addr", int'(spad_addr), 0);
    chk("postrst_wdata", int'(spad_wdata), 0);
    prod_q = '{7, 9};
    build_model(2, 1);
    run_job(2, 1, 1'b0, 1'b0);
    check_job(2, 1, 1'b0);

    // Start while busy must not disturb the running job
    prod_q = '{11, 22, 33, 44, 55, 66};
    build_model(3, 2);
    run_job(3, 2, 1'b0, 1'b1);
    check_job(3, 2, 1'b0);

    // Randomized jobs against the model
    for (int r = 0; r < 12; r++) begin
      len    = $urandom_range(1, 8);
      passes = $urandom_range(1, 6);
      stl    = 1'($urandom_range(0, 1));
      pk     = 1'($urandom_range(0, 1));
      prod_q.delete();
      for (int k = 0; k < len*passes; k++) prod_q.push_back($urandom_range(0, 255));
      build_model(len, passes);
      run_job(len, passes, stl, pk);
      check_job(len, passes, stl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
